// File: rtl/pci64_enum.sv
// Configuration-space enumeration master for the 64-bit config bus: scans one bus,
// sizes BAR0..BAR2 of each present function 0, assigns aligned bases and enables devices.
module pci64_enum #(
  parameter logic [7:0]  BUS       = 8'd0,
  parameter logic [5:0]  NDEV      = 6'd32,
  parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
  parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
  parameter logic [7:0]  TIMEOUT   = 8'd15,
  parameter logic [15:0] CMD_VAL   = 16'h0006
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [5:0]  dev_count_o,
  output logic [31:0] alloc_ptr_o,
  output logic        cs_config_o,
  output logic        we_o,
  output logic [7:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [63:0] dat_o,
  input  logic [63:0] dat_i,
  input  logic        ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ID, S_CHK_ID, S_SZ_WR, S_SZ_RD, S_CALC,
    S_BAR_WR, S_CMD_WR, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  dev_q;
  logic [1:0]  bar_q;
  logic [7:0]  tmo_q;
  logic [63:0] rd_q;
  logic [31:0] base_q;

  logic        is_access, acc_end;
  logic        req_we;
  logic [4:0]  req_idx;
  logic [7:0]  req_sel;
  logic [63:0] req_dat;
  logic [31:0] rd_lane, m, size;
  logic [32:0] size33, base33;
  logic [33:0] end34;
  logic        over;

  // BAR1 lives in the upper half of dword pair 2; BAR0 and BAR2 use the lower half.
  function automatic logic [63:0] place_lane(input logic [1:0] bar, input logic [31:0] v);
    return (bar == 2'd1) ? {v, 32'h0} : {32'h0, v};
  endfunction

  assign is_access = (state_q == S_RD_ID) || (state_q == S_SZ_WR) || (state_q == S_SZ_RD) ||
                     (state_q == S_BAR_WR) || (state_q == S_CMD_WR);
  assign acc_end   = cs_config_o && (ack_i || (tmo_q == TIMEOUT - 8'd1));

  // Size/base arithmetic is widened so a carry past 4 GiB reads as exhaustion.
  assign rd_lane = (bar_q == 2'd1) ? rd_q[63:32] : rd_q[31:0];
  assign m       = rd_lane & 32'hFFFF_FFF0;
  assign size    = ~m + 32'd1;
  assign size33  = {1'b0, size};
  assign base33  = ({1'b0, alloc_ptr_o} + size33 - 33'd1) & ~(size33 - 33'd1);
  assign end34   = {1'b0, base33} + {1'b0, size33} - 34'd1;
  assign over    = end34 > {2'b00, MEM_LIMIT};

  always_comb begin
    req_we  = 1'b0;
    req_idx = (bar_q == 2'd2) ? 5'd3 : 5'd2;
    req_sel = (bar_q == 2'd1) ? 8'hF0 : 8'h0F;
    req_dat = '0;
    case (state_q)
      S_RD_ID: begin
        req_idx = 5'd0;
        req_sel = 8'hFF;
      end
      S_SZ_WR: begin
        req_we  = 1'b1;
        req_dat = place_lane(bar_q, 32'hFFFF_FFFF);
      end
      S_BAR_WR: begin
        req_we  = 1'b1;
        req_dat = place_lane(bar_q, base_q);
      end
      S_CMD_WR: begin
        req_we  = 1'b1;
        req_idx = 5'd1;
        req_sel = 8'h03;
        req_dat = {48'h0, CMD_VAL};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_RD_ID;
      S_RD_ID:  if (acc_end) state_d = S_CHK_ID;
      S_CHK_ID: state_d = (rd_q[15:0] == 16'hFFFF) ? S_NEXT : S_SZ_WR;
      S_SZ_WR:  if (acc_end) state_d = S_SZ_RD;
      S_SZ_RD:  if (acc_end) state_d = S_CALC;
      S_CALC: begin
        if (m == 32'h0)  state_d = (bar_q == 2'd2) ? S_CMD_WR : S_SZ_WR;
        else if (over)   state_d = S_ERR;
        else             state_d = S_BAR_WR;
      end
      S_BAR_WR: if (acc_end) state_d = (bar_q == 2'd2) ? S_CMD_WR : S_SZ_WR;
      S_CMD_WR: if (acc_end) state_d = S_NEXT;
      S_NEXT:   state_d = (dev_q == NDEV - 6'd1) ? S_DONE : S_RD_ID;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      dev_count_o <= '0;
      alloc_ptr_o <= MEM_BASE;
      cs_config_o <= 1'b0;
      we_o        <= 1'b0;
      sel_o       <= '0;
      adr_o       <= '0;
      dat_o       <= '0;
      dev_q       <= '0;
      bar_q       <= '0;
      tmo_q       <= '0;
      rd_q        <= '0;
      base_q      <= '0;
    end else begin
      done_o <= 1'b0;
      if (state_q == S_IDLE && start_i) begin
        err_o       <= 1'b0;
        dev_count_o <= '0;
        alloc_ptr_o <= MEM_BASE;
        dev_q       <= '0;
        busy_o      <= 1'b1;
      end

      // Bus access: cs rises one cycle after entering an access state, so
      // back-to-back accesses always see at least one idle cycle.
      if (is_access && !cs_config_o) begin
        cs_config_o <= 1'b1;
        we_o        <= req_we;
        sel_o       <= req_sel;
        adr_o       <= {4'h0, BUS, dev_q[4:0], 3'b000, 4'h0, req_idx, 3'b000};
        dat_o       <= req_dat;
        tmo_q       <= '0;
      end else if (cs_config_o) begin
        if (acc_end) begin
          cs_config_o <= 1'b0;
          we_o        <= 1'b0;
          sel_o       <= '0;
          adr_o       <= '0;
          dat_o       <= '0;
          if (!we_o) rd_q <= ack_i ? dat_i : '1;
        end else begin
          tmo_q <= tmo_q + 8'd1;
        end
      end

      case (state_q)
        S_CHK_ID: if (rd_q[15:0] != 16'hFFFF) begin
          dev_count_o <= dev_count_o + 6'd1;
          bar_q       <= '0;
        end
        S_CALC: begin
          if (m == 32'h0) begin
            bar_q <= bar_q + 2'd1;
          end else if (!over) begin
            alloc_ptr_o <= base33[31:0] + size;
            base_q      <= base33[31:0];
          end
        end
        S_BAR_WR: if (acc_end) bar_q <= bar_q + 2'd1;
        S_NEXT:   dev_q <= dev_q + 6'd1;
        default: ;
      endcase

      if (state_d == S_DONE) begin
        done_o <= 1'b1;
        busy_o <= 1'b0;
      end
      if (state_d == S_ERR) begin
        err_o  <= 1'b1;
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pci64_enum.sv
// Directed bench for pci64_enum: a config-target model answers both instances
// (default window and a narrow window) and each scenario task checks its results.
`timescale 1ns/1ps
module tb_pci64_enum;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni, start1, start2;
  logic        busy1, done1, err1, cs1, we1;
  logic        busy2, done2, err2, cs2, we2;
  logic [5:0]  dc1, dc2;
  logic [31:0] ap1, ap2, adr1, adr2;
  logic [7:0]  sel1, sel2;
  logic [63:0] dat1, dat2;
  logic [63:0] dat_i;
  logic        ack_i;

  pci64_enum #(.NDEV(6'd2)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .err_o(err1), .dev_count_o(dc1), .alloc_ptr_o(ap1), .cs_config_o(cs1), .we_o(we1),
    .sel_o(sel1), .adr_o(adr1), .dat_o(dat1), .dat_i(dat_i), .ack_i(ack_i));

  pci64_enum #(.NDEV(6'd1), .MEM_LIMIT(32'h4000_FFFF)) u_dut_lim (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .err_o(err2), .dev_count_o(dc2), .alloc_ptr_o(ap2), .cs_config_o(cs2), .we_o(we2),
    .sel_o(sel2), .adr_o(adr2), .dat_o(dat2), .dat_i(dat_i), .ack_i(ack_i));

  logic        m_cs, m_we;
  logic [7:0]  m_sel;
  logic [31:0] m_adr;
  logic [63:0] m_dat;
  logic [4:0]  m_dev, m_idx;
  assign m_cs  = cs1 | cs2;
  assign m_we  = cs1 ? we1 : we2;
  assign m_sel = cs1 ? sel1 : sel2;
  assign m_adr = cs1 ? adr1 : adr2;
  assign m_dat = cs1 ? dat1 : dat2;
  assign m_dev = m_adr[19:15];
  assign m_idx = m_adr[7:3];

  // Config target model
  logic        ack_en [32];
  logic [31:0] mask    [32][3];
  logic [31:0] bar_reg [32][3];
  logic [15:0] cmd_reg [32];
  int lat = 1;
  int wcnt = 0, wr_cnt = 0, bar_wr_cnt = 0, cmd_cnt = 0;
  logic [31:0] last_bar_wr = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end else begin
      ack_i <= 1'b0;
      if (m_cs && !ack_i) begin
        if (wcnt >= lat) begin
          wcnt <= 0;
          if (ack_en[m_dev]) begin
            ack_i <= 1'b1;
            if (m_we) begin
              wr_cnt <= wr_cnt + 1;
              if (m_idx == 5'd2 && m_sel == 8'h0F) begin
                bar_reg[m_dev][0] <= m_dat[31:0];
                if (m_dat[31:0] != 32'hFFFF_FFFF) begin bar_wr_cnt <= bar_wr_cnt + 1; last_bar_wr <= m_dat[31:0]; end
              end else if (m_idx == 5'd2 && m_sel == 8'hF0) begin
                bar_reg[m_dev][1] <= m_dat[63:32];
                if (m_dat[63:32] != 32'hFFFF_FFFF) begin bar_wr_cnt <= bar_wr_cnt + 1; last_bar_wr <= m_dat[63:32]; end
              end else if (m_idx == 5'd3 && m_sel == 8'h0F) begin
                bar_reg[m_dev][2] <= m_dat[31:0];
                if (m_dat[31:0] != 32'hFFFF_FFFF) begin bar_wr_cnt <= bar_wr_cnt + 1; last_bar_wr <= m_dat[31:0]; end
              end else if (m_idx == 5'd1 && m_sel == 8'h03) begin
                cmd_reg[m_dev] <= m_dat[15:0];
                cmd_cnt <= cmd_cnt + 1;
              end
            end else begin
              case (m_idx)
                5'd0:    dat_i <= 64'h0000_0000_ABCD_1234;
                5'd2:    dat_i <= {bar_reg[m_dev][1] & mask[m_dev][1], bar_reg[m_dev][0] & mask[m_dev][0]};
                5'd3:    dat_i <= {32'h0, bar_reg[m_dev][2] & mask[m_dev][2]};
                default: dat_i <= 64'h0;
              endcase
            end
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  // Bus monitor
  int acc_cnt = 0, len15_cnt = 0, done_cnt = 0, unstable_cnt = 0, cur_len = 0;
  logic        prev_cs = 1'b0, prev_we = 1'b0;
  logic [7:0]  prev_sel = '0, cap_sel = '0;
  logic [31:0] prev_adr = '0, cap_adr = '0;
  logic [63:0] prev_dat = '0, cap_dat = '0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_cs <= 1'b0;
      cur_len <= 0;
    end else begin
      if (m_cs) begin
        cur_len <= cur_len + 1;
        if (!prev_cs) acc_cnt <= acc_cnt + 1;
        else if ({m_we, m_sel, m_adr, m_dat} != {prev_we, prev_sel, prev_adr, prev_dat})
          unstable_cnt <= unstable_cnt + 1;
        if (m_we && m_sel == 8'hF0 && m_dat[63:32] == 32'hFFFF_FFFF) begin
          cap_sel <= m_sel; cap_adr <= m_adr; cap_dat <= m_dat;
        end
      end else if (prev_cs) begin
        if (cur_len == 15) len15_cnt <= len15_cnt + 1;
        cur_len <= 0;
      end
      if (done1 || done2) done_cnt <= done_cnt + 1;
      prev_cs <= m_cs; prev_we <= m_we; prev_sel <= m_sel; prev_adr <= m_adr; prev_dat <= m_dat;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic clear_devs();
    for (int i = 0; i < 32; i++) begin
      ack_en[i] = 1'b0;
      for (int b = 0; b < 3; b++) mask[i][b] = 32'h0;
    end
  endtask

  task automatic run(input bit which, input int budget, output logic busy_after,
                     output logic busy_end, output bit fin_done, output bit fin_err, output bit t_out);
    @(negedge clk_i);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk_i);
    start1 = 1'b0; start2 = 1'b0;
    busy_after = which ? busy2 : busy1;
    fin_done = 1'b0; fin_err = 1'b0; t_out = 1'b1; busy_end = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (which ? done2 : done1) begin fin_done = 1'b1; t_out = 1'b0; end
      else if (which ? err2 : err1) begin fin_err = 1'b1; t_out = 1'b0; end
      if (!t_out) begin busy_end = which ? busy2 : busy1; break; end
      @(negedge clk_i);
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    n_chk++; if ({busy1, done1, err1, cs1, we1} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {busy1, done1, err1, cs1, we1}); end
    n_chk++; if (dc1 !== 6'd0) begin n_fail++; $display("FAIL reset_dev_count: got %0d required 0", dc1); end
    n_chk++; if (ap1 !== 32'h4000_0000) begin n_fail++; $display("FAIL reset_alloc_ptr: got %h required 40000000", ap1); end
    n_chk++; if ({sel1, adr1, dat1} !== 104'h0) begin n_fail++; $display("FAIL reset_bus: got sel %h adr %h dat %h required 0", sel1, adr1, dat1); end
  endtask

  task automatic test_single_bar();
    logic ba, be; bit d, e, t; int w0, b0, c0, d0, u0;
    clear_devs(); ack_en[0] = 1'b1; mask[0][0] = 32'hFFFF_F000; lat = 1;
    w0 = wr_cnt; b0 = bar_wr_cnt; c0 = cmd_cnt; d0 = done_cnt; u0 = unstable_cnt;
    run(1'b0, 3000, ba, be, d, e, t);
    n_chk++; if (ba !== 1'b1) begin n_fail++; $display("FAIL t1_busy_after_start: got %b required 1", ba); end
    n_chk++; if (!d || t) begin n_fail++; $display("FAIL t1_done_seen: got done=%0d timeout=%0d required done=1", d, t); end
    n_chk++; if (be !== 1'b0) begin n_fail++; $display("FAIL t1_busy_at_done: got %b required 0", be); end
    n_chk++; if (dc1 !== 6'd1) begin n_fail++; $display("FAIL t1_dev_count: got %0d required 1", dc1); end
    n_chk++; if (ap1 !== 32'h4000_1000) begin n_fail++; $display("FAIL t1_alloc_ptr: got %h required 40001000", ap1); end
    n_chk++; if (bar_reg[0][0] !== 32'h4000_0000) begin n_fail++; $display("FAIL t1_bar0: got %h required 40000000", bar_reg[0][0]); end
    n_chk++; if (cmd_reg[0] !== 16'h0006 || cmd_cnt - c0 != 1) begin n_fail++; $display("FAIL t1_cmd: got %h x%0d required 0006 x1", cmd_reg[0], cmd_cnt - c0); end
    n_chk++; if (wr_cnt - w0 != 5 || bar_wr_cnt - b0 != 1) begin n_fail++; $display("FAIL t1_writes: got %0d/%0d required 5/1", wr_cnt - w0, bar_wr_cnt - b0); end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t1_done_pulses: got %0d required 1", done_cnt - d0); end
    n_chk++; if (unstable_cnt != u0) begin n_fail++; $display("FAIL t1_bus_stable: got %0d changes required 0", unstable_cnt - u0); end
  endtask

  task automatic test_three_bars();
    logic ba, be; bit d, e, t; int b0;
    clear_devs(); ack_en[1] = 1'b1; lat = 0;
    mask[1][0] = 32'hFFFF_FF00; mask[1][1] = 32'hFFFF_0000; mask[1][2] = 32'hFFFF_FFF0;
    b0 = bar_wr_cnt;
    run(1'b0, 3000, ba, be, d, e, t);
    n_chk++; if (!d || t) begin n_fail++; $display("FAIL t2_done_seen: got done=%0d timeout=%0d required done=1", d, t); end
    n_chk++; if (bar_reg[1][0] !== 32'h4000_0000) begin n_fail++; $display("FAIL t2_bar0: got %h required 40000000", bar_reg[1][0]); end
    n_chk++; if (bar_reg[1][1] !== 32'h4001_0000) begin n_fail++; $display("FAIL t2_bar1: got %h required 40010000", bar_reg[1][1]); end
    n_chk++; if (bar_reg[1][2] !== 32'h4002_0000) begin n_fail++; $display("FAIL t2_bar2: got %h required 40020000", bar_reg[1][2]); end
    n_chk++; if (ap1 !== 32'h4002_0010) begin n_fail++; $display("FAIL t2_alloc_ptr: got %h required 40020010", ap1); end
    n_chk++; if (dc1 !== 6'd1 || bar_wr_cnt - b0 != 3) begin n_fail++; $display("FAIL t2_count: got dev %0d bars %0d required 1/3", dc1, bar_wr_cnt - b0); end
    n_chk++; if (cap_sel !== 8'hF0) begin n_fail++; $display("FAIL t2_bar1_size_sel: got %h required f0", cap_sel); end
    n_chk++; if (cap_adr !== 32'h0000_8010) begin n_fail++; $display("FAIL t2_bar1_size_adr: got %h required 00008010", cap_adr); end
    n_chk++; if (cap_dat !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL t2_bar1_size_dat: got %h required ffffffff00000000", cap_dat); end
  endtask

  task automatic test_no_ack();
    logic ba, be; bit d, e, t; int w0, a0, l0, d0;
    clear_devs(); lat = 1;
    w0 = wr_cnt; a0 = acc_cnt; l0 = len15_cnt; d0 = done_cnt;
    run(1'b0, 3000, ba, be, d, e, t);
    n_chk++; if (!d || t) begin n_fail++; $display("FAIL t3_done_seen: got done=%0d timeout=%0d required done=1", d, t); end
    n_chk++; if (dc1 !== 6'd0) begin n_fail++; $display("FAIL t3_dev_count: got %0d required 0", dc1); end
    n_chk++; if (wr_cnt != w0) begin n_fail++; $display("FAIL t3_writes: got %0d required 0", wr_cnt - w0); end
    n_chk++; if (acc_cnt - a0 != 2 || len15_cnt - l0 != 2) begin n_fail++; $display("FAIL t3_abort_len: got %0d accesses %0d of 15 cycles required 2/2", acc_cnt - a0, len15_cnt - l0); end
    n_chk++; if (ap1 !== 32'h4000_0000 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL t3_alloc_done: got %h x%0d required 40000000 x1", ap1, done_cnt - d0); end
  endtask

  task automatic test_window_limit();
    logic ba, be; bit d, e, t; int b0, d0;
    clear_devs(); ack_en[0] = 1'b1; mask[0][0] = 32'hFFFE_0000; lat = 1;
    b0 = bar_wr_cnt; d0 = done_cnt;
    run(1'b1, 3000, ba, be, d, e, t);
    n_chk++; if (!e || d || t) begin n_fail++; $display("FAIL t4_err_end: got err=%0d done=%0d timeout=%0d required err only", e, d, t); end
    n_chk++; if (err2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL t4_err_sticky: got err %b busy %b required 1/0", err2, busy2); end
    n_chk++; if (bar_wr_cnt != b0 || done_cnt != d0) begin n_fail++; $display("FAIL t4_no_bar_wr: got bars %0d done %0d required 0/0", bar_wr_cnt - b0, done_cnt - d0); end
    n_chk++; if (ap2 !== 32'h4000_0000 || dc2 !== 6'd1) begin n_fail++; $display("FAIL t4_state: got alloc %h dev %0d required 40000000/1", ap2, dc2); end
    // allocation ending exactly on the window limit is accepted
    mask[0][0] = 32'hFFFF_0000;
    run(1'b1, 3000, ba, be, d, e, t);
    n_chk++; if (!d || t || err2 !== 1'b0) begin n_fail++; $display("FAIL t4b_done: got done=%0d timeout=%0d err=%b required done, err 0", d, t, err2); end
    n_chk++; if (ap2 !== 32'h4001_0000) begin n_fail++; $display("FAIL t4b_alloc_ptr: got %h required 40010000", ap2); end
    n_chk++; if (bar_reg[0][0] !== 32'h4000_0000 || last_bar_wr !== 32'h4000_0000) begin n_fail++; $display("FAIL t4b_bar0: got %h required 40000000", bar_reg[0][0]); end
  endtask

  task automatic test_reset_mid();
    logic ba, be; bit d, e, t, hit; int d0;
    clear_devs(); ack_en[0] = 1'b1; mask[0][0] = 32'hFFFF_F000; lat = 8;
    d0 = done_cnt; hit = 1'b0;
    @(negedge clk_i); start1 = 1'b1;
    @(negedge clk_i); start1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (cs1 && !we1 && adr1[7:3] == 5'd2) begin hit = 1'b1; break; end
      @(negedge clk_i);
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL t6_reach_sz_rd: got no sizing read required one"); end
    #2 rst_ni = 1'b0;
    #1;
    n_chk++; if ({cs1, busy1, done1, we1} !== 4'b0) begin n_fail++; $display("FAIL t6_async_drop: got %b required 0000", {cs1, busy1, done1, we1}); end
    n_chk++; if ({sel1, adr1, dat1} !== 104'h0 || dc1 !== 6'd0 || ap1 !== 32'h4000_0000) begin n_fail++; $display("FAIL t6_reset_vals: got dev %0d alloc %h required 0/40000000", dc1, ap1); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1; lat = 1;
    @(negedge clk_i); start1 = 1'b1;
    @(negedge clk_i); start1 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cs1) begin hit = 1'b1; break; end
      @(negedge clk_i);
    end
    n_chk++; if (!hit || adr1 !== 32'h0 || sel1 !== 8'hFF || we1 !== 1'b0) begin n_fail++; $display("FAIL t6_first_access: got cs %b adr %h sel %h required adr 0 sel ff read", hit, adr1, sel1); end
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done1) begin d = 1'b1; break; end
      @(negedge clk_i);
    end
    repeat (3) @(negedge clk_i);
    n_chk++; if (!d || dc1 !== 6'd1 || ap1 !== 32'h4000_1000) begin n_fail++; $display("FAIL t6_reenum: got done=%0d dev %0d alloc %h required 1/1/40001000", d, dc1, ap1); end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t6_done_pulses: got %0d required 1", done_cnt - d0); end
    ba = 1'b0; be = 1'b0; e = 1'b0; t = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start1 = 1'b0; start2 = 1'b0;
    clear_devs();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    test_reset();
    test_single_bar();
    test_three_bars();
    test_no_ack();
    test_window_limit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pci64_enum.md
Name: pci64_enum

Overview:
- Configuration-space enumeration master for the 64-bit config bus.
- After start, scans device slots on one bus (function 0 only) and detects present devices from their vendor ID.
- Sizes BAR0..BAR2 of each present device, assigns aligned base addresses from one memory window, then enables each device's memory-space and bus-master bits.
- Sits between the boot/system controller and the config targets; drives their chip-select, address, write-enable, byte-select and data lines.

Parameters:
- BUS, 8'd0, bus number placed in adr_o[27:20]
- NDEV, 6'd32, number of device slots scanned (0..NDEV-1, max 32)
- MEM_BASE, 32'h4000_0000, first byte of the allocation window
- MEM_LIMIT, 32'h7FFF_FFFF, last byte of the allocation window (inclusive)
- TIMEOUT, 8'd15, ack wait cycles before master abort
- CMD_VAL, 16'h0006, value written to the command register (memory space + bus master)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  begin enumeration (sampled in IDLE only)
- busy_o  out  1  high from the cycle after start_i until DONE/ERR
- done_o  out  1  one-cycle pulse on completion
- err_o  out  1  sticky window exhaustion; cleared by next start_i
- dev_count_o  out  6  present devices found
- alloc_ptr_o  out  32  next free address
- cs_config_o  out  1  config access request, held until ack
- we_o  out  1  write strobe
- sel_o  out  8  byte lane selects
- adr_o  out  32  config address: [27:20] bus, [19:15] device, [14:12]=0, [7:3] dword-pair index, others 0
- dat_o  out  64  write data
- dat_i  in  64  read data
- ack_i  in  1  access complete; read data valid this cycle

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0 except alloc_ptr_o=MEM_BASE.
- Bus handshake:
  - cs_config_o, we_o, sel_o, adr_o and dat_o are registered and stable until the ack cycle.
  - cs_config_o drops the cycle after ack_i.
  - Read data is captured only on the ack_i cycle.
  - If ack_i is absent after TIMEOUT cycles, this is a master abort: the access ends, and reads return 64'hFFFF_FFFF_FFFF_FFFF.
  - Minimum 1 idle cycle between accesses.
- States: IDLE -> RD_ID -> CHK_ID -> (SZ_WR -> SZ_RD -> CALC -> BAR_WR) x3 -> CMD_WR -> NEXT -> ... -> DONE -> IDLE; ERR -> IDLE.
- IDLE, on start_i:
  - clear err_o and dev_count_o;
  - set alloc_ptr_o=MEM_BASE;
  - set dev=0;
  - set busy_o the next cycle.
- RD_ID: read index 0, sel 8'hFF.
- CHK_ID: if dat[15:0]==16'hFFFF, go to NEXT (device absent); otherwise increment dev_count_o and set bar=0.
- SZ_WR: write 32'hFFFF_FFFF to the BAR.
  - BAR0: index 2, sel 8'h0F, dat_o[31:0].
  - BAR1: index 2, sel 8'hF0, dat_o[63:32].
  - BAR2: index 3, sel 8'h0F.
  - Unused lanes in dat_o are 0.
- SZ_RD: read the same index; mask = selected 32-bit lane.
- CALC, with m = mask & 32'hFFFF_FFF0:
  - m==0: BAR unimplemented; skip BAR_WR and go to the next bar.
  - Otherwise size = ~m + 1, base = (alloc_ptr + size - 1) & ~(size - 1), computed in 33 bits.
  - If base + size - 1 > MEM_LIMIT or a carry out occurs: go to ERR (err_o=1, busy_o=0, no done_o).
  - Otherwise alloc_ptr <= base + size.
- BAR_WR: write base to the BAR's lane/sel; then bar+1, or CMD_WR after BAR2.
- CMD_WR: write index 1, sel 8'h03, dat_o[15:0]=CMD_VAL.
- NEXT: dev+1; if dev==NDEV-1, go to DONE, else RD_ID.
- DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
- start_i is ignored while busy.
- Reset mid-transaction aborts immediately: cs_config_o drops asynchronously with no completion pulse.
- ack_i outside an active access is ignored.
- alloc_ptr_o is exact, with no wrap; an allocation ending exactly at MEM_LIMIT is legal.

Test Plan:
- Device 0 only, BAR0 mask FFFF_F000, others 0, NDEV=2: expect writes BAR0=4000_0000, cmd=0006; dev_count_o=1; alloc_ptr_o=4000_1000; done_o pulses once.
- Device 1 BAR0 mask FFFF_FF00, BAR1 FFFF_0000, BAR2 FFFF_FFF0: expect BAR0=4000_0000, BAR1=4001_0000, BAR2=4002_0000, alloc_ptr_o=4002_0010.
- No device acks, TIMEOUT=15: each slot aborts after 15 cycles; dev_count_o=0; done_o asserted; no writes issued.
- MEM_LIMIT=4000_FFFF, BAR0 mask FFFE_0000: expect err_o=1, busy_o=0, no BAR_WR, no done_o.
- Sizing access on BAR1: adr_o[7:3]=2, sel_o=F0, dat_o=FFFF_FFFF_0000_0000; BAR0 lane untouched.
- rst_ni low during SZ_RD wait: all outputs 0 immediately; a new start_i re-enumerates from device 0.
